// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer for a reg16 bank: IDLE -> SETUP -> XFER -> DONE, one request per 4 cycles.
// Latency: done 3 cycles after accept. Optional macro R0_PROTECT_EN makes register 0 write-protected.
module reg_xfer_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IDXW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [IDXW-1:0]   req_dst,
  input  logic [IDXW-1:0]   req_src,
  input  logic [IDXW-1:0]   req_src2,
  input  logic [WIDTH-1:0]  req_imm,
  output logic [NREGS-1:0]  reg_en,
  output logic [NREGS-1:0]  reg_selA,
  output logic [NREGS-1:0]  reg_selB,
  output logic              bus_sel,
  output logic [WIDTH-1:0]  bus_imm,
  output logic              rd_valid,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_RD2 = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

  state_t state_q, state_nxt;

  logic [1:0]       op_q;
  logic [IDXW-1:0]  dst_q, src_q, src2_q;
  logic [WIDTH-1:0] imm_q;
  logic             bad_q, bad_d;

  logic [1:0]       cur_op;
  logic [IDXW-1:0]  cur_dst, cur_src, cur_src2;
  logic [WIDTH-1:0] cur_imm;
  logic             cur_bad, cur_prot;
  logic             accept;

  logic             rdy_d, bsel_d, rdv_d, done_d, err_d;
  logic [NREGS-1:0] en_d, sela_d, selb_d;
  logic [WIDTH-1:0] bimm_d;

  function automatic logic idx_ok(input logic [IDXW-1:0] i);
    return 32'(i) < NREGS;
  endfunction

  function automatic logic [NREGS-1:0] onehot(input logic [IDXW-1:0] i);
    return {{(NREGS-1){1'b0}}, 1'b1} << i;
  endfunction

  assign accept = req_valid && req_ready;

  // Any illegal opcode or out-of-range index turns the request into a no-op.
  always_comb begin
    bad_d = 1'b0;
    case (req_op)
      OP_MOV:  bad_d = !idx_ok(req_src) || !idx_ok(req_dst);
      OP_LDI:  bad_d = !idx_ok(req_dst);
      OP_RD2:  bad_d = !idx_ok(req_src) || !idx_ok(req_src2);
      default: bad_d = 1'b1;
    endcase
  end

`ifdef R0_PROTECT_EN
  logic prot_q, prot_d;
  assign prot_d = (req_op == OP_MOV || req_op == OP_LDI) && (req_dst == '0);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        prot_q <= 1'b0;
    else if (accept) prot_q <= prot_d;
  end
  assign cur_prot = accept ? prot_d : prot_q;
`else
  assign cur_prot = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_RSV;
      dst_q  <= '0;
      src_q  <= '0;
      src2_q <= '0;
      imm_q  <= '0;
      bad_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= req_op;
      dst_q  <= req_dst;
      src_q  <= req_src;
      src2_q <= req_src2;
      imm_q  <= req_imm;
      bad_q  <= bad_d;
    end
  end

  // Outputs are decoded from the upcoming state, so on accept the fresh request fields are used.
  assign cur_op   = accept ? req_op   : op_q;
  assign cur_dst  = accept ? req_dst  : dst_q;
  assign cur_src  = accept ? req_src  : src_q;
  assign cur_src2 = accept ? req_src2 : src2_q;
  assign cur_imm  = accept ? req_imm  : imm_q;
  assign cur_bad  = accept ? bad_d    : bad_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = XFER;
      XFER:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy_d  = (state_nxt == IDLE);
    en_d   = '0;
    sela_d = '0;
    selb_d = '0;
    bsel_d = 1'b0;
    bimm_d = '0;
    rdv_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_nxt)
      SETUP, XFER: begin
        if (!cur_bad) begin
          if (cur_op == OP_MOV || cur_op == OP_RD2) sela_d = onehot(cur_src);
          if (cur_op == OP_RD2)                     selb_d = onehot(cur_src2);
          bsel_d = (cur_op == OP_MOV);
          if (cur_op == OP_LDI)                     bimm_d = cur_imm;
          if (state_nxt == XFER) begin
            if ((cur_op == OP_MOV || cur_op == OP_LDI) && !cur_prot) en_d = onehot(cur_dst);
            rdv_d = (cur_op == OP_RD2);
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        err_d  = cur_bad || cur_prot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b1;
      reg_en    <= '0;
      reg_selA  <= '0;
      reg_selB  <= '0;
      bus_sel   <= 1'b0;
      bus_imm   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      req_ready <= rdy_d;
      reg_en    <= en_d;
      reg_selA  <= sela_d;
      reg_selB  <= selb_d;
      bus_sel   <= bsel_d;
      bus_imm   <= bimm_d;
      rd_valid  <= rdv_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
- Transfer sequencer that drives the load-enable and A/B read-select lines of a bank of reg16 registers sharing one write bus and two read buses (A, B).
- Accepts one register-transfer request at a time over a valid/ready handshake.
- Produces the multi-cycle select/enable sequence to move, load or read register data, then pulses done.
- Sits between instruction decode and the register bank.

Parameters:
- WIDTH, 16: data width of immediate and bus.
- NREGS, 8: number of registers in the bank.
- IDXW, 3: register index width; must satisfy 2**IDXW >= NREGS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  00 MOV (dst <= src), 01 LDI (dst <= imm), 10 RD2 (src on A, src2 on B), 11 reserved.
- req_dst  in  IDXW  destination index.
- req_src  in  IDXW  source index, read on A.
- req_src2  in  IDXW  second source index, read on B (RD2 only).
- req_imm  in  WIDTH  immediate for LDI.
- reg_en  out  NREGS  one-hot load enable to the register bank.
- reg_selA  out  NREGS  one-hot A-bus select.
- reg_selB  out  NREGS  one-hot B-bus select.
- bus_sel  out  1  write-bus source: 0 = bus_imm, 1 = A bus pass-through.
- bus_imm  out  WIDTH  immediate driven to the write-bus mux.
- rd_valid  out  1  A/B buses hold the RD2 operands this cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0 except req_ready = 1.
  - A request in flight is abandoned and no enable is asserted after reset.
- State IDLE:
  - req_ready = 1.
  - Accept when req_valid && req_ready at a rising edge.
  - Latch op, indices and immediate into internal registers; later input changes are ignored.
  - Go to SETUP.
- State SETUP (1 cycle): req_ready = 0.
  - MOV: reg_selA[src] = 1, bus_sel = 1.
  - LDI: bus_imm = imm, bus_sel = 0.
  - RD2: reg_selA[src] = 1, reg_selB[src2] = 1.
  - Go to XFER.
- State XFER (1 cycle): selects, bus_sel and bus_imm are held from SETUP.
  - MOV/LDI: reg_en[dst] = 1, so the register loads at the closing edge.
  - RD2: rd_valid = 1, no enable.
  - Go to DONE.
- State DONE (1 cycle):
  - reg_en, reg_selA, reg_selB, rd_valid, bus_sel and bus_imm all return to 0.
  - done = 1; go to IDLE.
- Latency: accept edge to done = 3 cycles. Back-to-back throughput is one request per 4 cycles; the next accept happens in the IDLE cycle after DONE.
- MOV with src == dst is legal: selA and en on the same register in XFER; the register reloads its own value.
- RD2 with src == src2 is legal: selA and selB of the same register are both asserted.
- Error cases, each giving a no-op sequence (no en, no selects) with err = 1 alongside done, same latency:
  - op 11;
  - any used index >= NREGS.
- reg_en, reg_selA and reg_selB are never more than one-hot. reg_en is asserted only in XFER.
- All outputs are registered; no combinational path from req_* to reg_* outputs.

Optional Feature:
- Macro R0_PROTECT_EN.
- Defined: register 0 is write-protected.
  - MOV or LDI with dst == 0 executes SETUP/XFER with reg_en forced to all-zero.
  - err = 1 alongside done.
  - Reads of register 0 are unaffected.
- Undefined: register 0 is an ordinary register; no protection logic is compiled.

Test Plan:
- Reset: hold rst low mid-transfer (during XFER) -> reg_en = 0, done = 0, req_ready = 1 immediately, asynchronously; after release the bank still holds its old value.
- LDI: op 01, dst 3, imm 16'hF0F0 -> SETUP bus_sel = 0, bus_imm = F0F0; XFER reg_en = 8'b00001000; register 3 reads F0F0 afterwards; done at accept + 3.
- MOV: preload r3 = F0F0; op 00, src 3, dst 5 -> reg_selA = 8'b00001000 for 2 cycles, bus_sel = 1, reg_en = 8'b00100000 in XFER; r5 = F0F0; done pulses once.
- RD2: r3 = F0F0, r5 = CCCC; op 10, src 3, src2 5 -> rd_valid high 1 cycle with A = F0F0, B = CCCC; reg_en stays 0.
- Errors: op 11 -> no enables or selects, err = done = 1 at accept + 3. With R0_PROTECT_EN, LDI dst 0 imm 1234 -> r0 unchanged, err = 1.
- Handshake: req_valid held high with 2 queued requests -> req_ready low for 3 cycles, second accept exactly 4 cycles after the first; inputs changed mid-transfer are ignored.
